alu_share_arb: RTL and testbench

//  Shares one 2-bit combinational ALU (sel=0: ain+bin mod 4; sel=1: ain&bin) among NREQ requesters.

---
 rtl/alu_share_arb_pkg.sv | 15 +
 rtl/alu_share_arb_rr_pick.sv | 37 +++
 rtl/alu_share_arb.sv | 150 +++++++++++++++
 tb/tb_alu_share_arb.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the ALU-sharing arbiter.
package alu_share_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_AND = 1'b1;
    localparam int   CNT_W  = 8;

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i, wrapping.
module alu_share_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    // One extra bit so ptr+k can exceed NREQ-1 before the wrap subtract.
    logic [IW:0] cand;
    logic        found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!found && valid_i[cand[IW-1:0]]) begin
                found                   = 1'b1;
                grant_o[cand[IW-1:0]]   = 1'b1;
                idx_o                   = cand[IW-1:0];
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one external 2-bit ALU among NREQ requesters, one op in flight.
// Optional per-requester accept counters on grant_cnt when ALU_SHARE_ARB_STATS_EN is defined.
//   state   | meaning
//   IDLE    | arbitrate; pulse req_ready and latch operands of the winner
//   ISSUE   | ALU settles on the registered operands
//   CAPTURE | register alu_zout into rsp_data
//   RESP    | hold rsp_valid for the winner until its rsp_ready
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_ain,
    input  logic [NREQ*DW-1:0] req_bin,
    input  logic [NREQ-1:0]    req_sel,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [DW-1:0]      rsp_data,
    output logic [DW-1:0]      alu_ain,
    output logic [DW-1:0]      alu_bin,
    output logic               alu_sel,
    input  logic [DW-1:0]      alu_zout
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

    localparam int IW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [DW-1:0]   ain_q, ain_d;
    logic [DW-1:0]   bin_q, bin_d;
    logic            sel_q, sel_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    alu_share_arb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        ain_d     = ain_q;
        bin_d     = bin_q;
        sel_d     = sel_q;
        rdata_d   = rdata_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                // rst_n gate keeps req_ready quiet while reset is held
                if (pick_any && rst_n) begin
                    req_ready = pick_grant;
                    gidx_d    = pick_idx;
                    ain_d     = req_ain[int'(pick_idx)*DW +: DW];
                    bin_d     = req_bin[int'(pick_idx)*DW +: DW];
                    sel_d     = req_sel[pick_idx];
                    ptr_d     = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + IW'(1);
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rdata_d = alu_zout;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[gidx_q] = 1'b1;
                if (rsp_ready[gidx_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            ain_q   <= '0;
            bin_q   <= '0;
            sel_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            ain_q   <= ain_d;
            bin_q   <= bin_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
        end
    end

    assign alu_ain  = ain_q;
    assign alu_bin  = bin_q;
    assign alu_sel  = sel_q;
    assign rsp_data = rdata_q;

`ifdef ALU_SHARE_ARB_STATS_EN
    logic [NREQ*CNT_W-1:0] cnt_q, cnt_d;

    // Saturating at all-ones; req_ready is already the one-hot accept pulse.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && (cnt_q[i*CNT_W +: CNT_W] != '1)) begin
                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: vector table, corner sequences, random vs. transaction model.
// Covers grant_cnt as well when ALU_SHARE_ARB_STATS_EN is defined.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_ain;
    logic [NREQ*DW-1:0] req_bin;
    logic [NREQ-1:0]    req_sel;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [DW-1:0]      rsp_data;
    logic [DW-1:0]      alu_ain;
    logic [DW-1:0]      alu_bin;
    logic               alu_sel;
    logic [DW-1:0]      alu_zout;
`ifdef ALU_SHARE_ARB_STATS_EN
    logic [NREQ*CNT_W-1:0] grant_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // The shared ALU lives outside the DUT.
    assign alu_zout = (alu_sel == OP_AND) ? (alu_ain & alu_bin) : DW'(alu_ain + alu_bin);

    alu_share_arb #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ain   (req_ain),
        .req_bin   (req_bin),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .alu_ain   (alu_ain),
        .alu_bin   (alu_bin),
        .alu_sel   (alu_sel),
        .alu_zout  (alu_zout)
`ifdef ALU_SHARE_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    typedef struct {
        int idx;
        int ain;
        int bin;
        int sel;
        int exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_alu(input int a, input int b, input int s);
        if (s == int'(OP_AND)) return DW'(a & b);
        return DW'((a + b) % (1 << DW));
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r = -1;
        int n = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                r = i;
                n++;
            end
        end
        return (n == 1) ? r : -1;
    endfunction

    task automatic quiet_inputs();
        req_valid = '0;
        req_ain   = '0;
        req_bin   = '0;
        req_sel   = '0;
        rsp_ready = '1;
    endtask

    // Called at a negedge; leaves at a negedge with the DUT idle.
    task automatic apply_reset();
        quiet_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_op(input int idx, input int ain, input int bin, input int sel,
                         input int exp, input string tag);
        int lat;
        bit got;
        quiet_inputs();
        req_valid[idx]            = 1'b1;
        req_ain[idx*DW +: DW]     = DW'(ain);
        req_bin[idx*DW +: DW]     = DW'(bin);
        req_sel[idx]              = sel[0];
        got = 1'b0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (req_ready != '0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_accept_seen"}, 32'(got), 32'd1);
        check({tag, "_ready_onehot"}, 32'(req_ready), 32'(1 << idx));
        @(posedge clk);
        #1;
        req_valid = '0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (rsp_valid != '0) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << idx));
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp));
        check({tag, "_alu_ain"}, 32'(alu_ain), 32'(ain));
        check({tag, "_alu_bin"}, 32'(alu_bin), 32'(bin));
        check({tag, "_alu_sel"}, 32'(alu_sel), 32'(sel));
        @(negedge clk);
        check({tag, "_rsp_dropped"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic test_backpressure();
        bit got = 1'b0;
        int w = 0;
        quiet_inputs();
        req_valid          = 4'b0100;
        req_ain[2*DW +: DW] = 2'd3;
        req_bin[2*DW +: DW] = 2'd2;
        req_sel[2]          = OP_AND;
        rsp_ready           = 4'b1011;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (req_ready[2]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("bp_accept_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 4'b1011;
        while (w < 10 && rsp_valid == '0) begin
            @(negedge clk);
            w++;
        end
        for (int c = 0; c < 10; c++) begin
            check("bp_rsp_valid_held", 32'(rsp_valid), 32'h4);
            check("bp_rsp_data_frozen", 32'(rsp_data), 32'd2);
            check("bp_no_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = '1;
        @(negedge clk);
        check("bp_released", 32'(rsp_valid), 32'd0);
    endtask

    task automatic test_midreset();
        quiet_inputs();
        req_valid           = 4'b0100;
        req_ain[2*DW +: DW] = 2'd1;
        req_bin[2*DW +: DW] = 2'd2;
        #1;
        check("mr_accept", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_alu_ain", 32'(alu_ain), 32'd0);
        check("mr_alu_bin", 32'(alu_bin), 32'd0);
        check("mr_rsp_data", 32'(rsp_data), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mr_no_rsp_in_reset", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mr_no_rsp_after", 32'(rsp_valid), 32'd0);
        end
        req_valid = '1;
        #1;
        check("mr_grant_from_ptr0", 32'(req_ready), 32'h1);
    endtask

    task automatic test_rotation();
        int acc_cyc[8];
        int acc_idx[8];
        int n_acc = 0;
        int ri;
        logic [DW-1:0] exp_d [NREQ];
        quiet_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req_ain[i*DW +: DW] = DW'($urandom);
            req_bin[i*DW +: DW] = DW'($urandom);
            req_sel[i]          = 1'($urandom);
            exp_d[i] = ref_alu(int'(req_ain[i*DW +: DW]), int'(req_bin[i*DW +: DW]), int'(req_sel[i]));
        end
        req_valid = '1;
        for (int c = 0; c < 36; c++) begin
            #1;
            if (req_ready != '0 && n_acc < 8) begin
                acc_cyc[n_acc] = c;
                acc_idx[n_acc] = onehot_idx(req_ready);
                n_acc++;
            end
            if (rsp_valid != '0) begin
                ri = onehot_idx(rsp_valid);
                if (ri >= 0) check("rot_rsp_data", 32'(rsp_data), 32'(exp_d[ri]));
                else check("rot_rsp_onehot", 32'(rsp_valid), 32'd0);
            end
            @(negedge clk);
        end
        check("rot_accept_count", 32'(n_acc), 32'd8);
        for (int k = 0; k < n_acc; k++) begin
            check("rot_grant_order", 32'(acc_idx[k]), 32'(k % NREQ));
            if (k > 0) check("rot_interval", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd4);
        end
        quiet_inputs();
        repeat (6) @(negedge clk);
    endtask

    // Transaction-level model: free arbiter picks from ptr; result appears 3 cycles after accept.
    task automatic test_random(input int ncyc);
        int mptr = 0;
        int mg = 0;
        int age = 0;
        int g;
        int c;
        bit busy = 1'b0;
        logic [DW-1:0]   mres = '0;
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rv;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            req_valid = NREQ'($urandom_range(0, 15));
            req_ain   = (NREQ*DW)'($urandom);
            req_bin   = (NREQ*DW)'($urandom);
            req_sel   = NREQ'($urandom);
            rsp_ready = NREQ'($urandom);
            #1;
            exp_ready = '0;
            exp_rv    = '0;
            g = -1;
            if (!busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (mptr + k) % NREQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end else if (age >= 3) begin
                exp_rv[mg] = 1'b1;
            end
            check("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
            check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (busy && age >= 3) check("rnd_rsp_data", 32'(rsp_data), 32'(mres));
            if (!busy) begin
                if (g >= 0) begin
                    busy = 1'b1;
                    age  = 1;
                    mg   = g;
                    mres = ref_alu(int'(req_ain[g*DW +: DW]), int'(req_bin[g*DW +: DW]), int'(req_sel[g]));
                    mptr = (g + 1) % NREQ;
                end
            end else if (age >= 3) begin
                if (rsp_ready[mg]) busy = 1'b0;
            end else begin
                age++;
            end
            @(negedge clk);
        end
        quiet_inputs();
        repeat (8) @(negedge clk);
    endtask

`ifdef ALU_SHARE_ARB_STATS_EN
    task automatic test_stats();
        int n_acc = 0;
        int cyc = 0;
        quiet_inputs();
        req_valid = 4'b0010;
        while (n_acc < 300 && cyc < 1400) begin
            #1;
            if (req_ready[1]) n_acc++;
            if (n_acc == 100 && req_ready[1]) begin
                @(posedge clk);
                #1;
                check("stats_cnt1_at_100", 32'(grant_cnt[1*CNT_W +: CNT_W]), 32'd100);
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        repeat (6) @(negedge clk);
        check("stats_accepts", 32'(n_acc), 32'd300);
        check("stats_cnt1_sat", 32'(grant_cnt[1*CNT_W +: CNT_W]), 32'd255);
        check("stats_cnt0", 32'(grant_cnt[0*CNT_W +: CNT_W]), 32'd0);
        check("stats_cnt2", 32'(grant_cnt[2*CNT_W +: CNT_W]), 32'd0);
        check("stats_cnt3", 32'(grant_cnt[3*CNT_W +: CNT_W]), 32'd0);
    endtask
`endif

    initial begin
        vec_t vecs[8];
        vecs[0] = '{idx: 0, ain: 3, bin: 2, sel: 0, exp: 1};
        vecs[1] = '{idx: 1, ain: 3, bin: 2, sel: 1, exp: 2};
        vecs[2] = '{idx: 2, ain: 1, bin: 1, sel: 0, exp: 2};
        vecs[3] = '{idx: 3, ain: 2, bin: 1, sel: 1, exp: 0};
        vecs[4] = '{idx: 0, ain: 3, bin: 3, sel: 0, exp: 2};
        vecs[5] = '{idx: 3, ain: 2, bin: 3, sel: 0, exp: 1};
        vecs[6] = '{idx: 2, ain: 3, bin: 3, sel: 1, exp: 3};
        vecs[7] = '{idx: 1, ain: 0, bin: 0, sel: 0, exp: 0};

        quiet_inputs();
        req_valid = '1;
        rsp_ready = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_alu_ain", 32'(alu_ain), 32'd0);
        check("rst_alu_bin", 32'(alu_bin), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
`ifdef ALU_SHARE_ARB_STATS_EN
        check("rst_grant_cnt", 32'(grant_cnt), 32'd0);
`endif
        quiet_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            do_op(vecs[v].idx, vecs[v].ain, vecs[v].bin, vecs[v].sel, vecs[v].exp,
                  $sformatf("vec%0d", v));
        end

        test_backpressure();
        test_midreset();
        apply_reset();
        test_rotation();
        apply_reset();
        test_random(400);
`ifdef ALU_SHARE_ARB_STATS_EN
        apply_reset();
        test_stats();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
